// File: rtl/hilo_mul_stage_pkg.sv
// Shared ALU definitions for the HI/LO multiply stage: FSM encoding and default width.
package hilo_mul_stage_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/hilo_mul_stage_mul.sv
// Combinational radix-2 Booth multiplier: full signed 2*DATA_WIDTH product split into HI/LO.
module mul
  import hilo_mul_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] Q,
  input  logic [DATA_WIDTH-1:0] M,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  logic [2*DATA_WIDTH-1:0] q_ext;
  logic [DATA_WIDTH:0]     m_ext;
  logic [2*DATA_WIDTH-1:0] pp [DATA_WIDTH];
  logic [2*DATA_WIDTH-1:0] sum;

  assign q_ext = {{DATA_WIDTH{Q[DATA_WIDTH-1]}}, Q};
  // Implicit zero below the LSB of M starts the Booth pair scan.
  assign m_ext = {M, 1'b0};

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_pp
    logic [1:0]              pair;
    logic [2*DATA_WIDTH-1:0] shifted;
    assign pair    = m_ext[gi+1:gi];
    assign shifted = q_ext << gi;
    assign pp[gi]  = (pair == 2'b01) ? shifted :
                     (pair == 2'b10) ? -shifted : '0;
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      sum = sum + pp[i];
    end
  end

  assign {HI, LO} = sum;

endmodule

// File: rtl/hilo_mul_stage.sv
// Multicycle signed multiply feeding architected HI/LO registers, with direct mthi/mtlo writes.
module hilo_mul_stage
  import hilo_mul_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] Q,
  input  logic [DATA_WIDTH-1:0] M,
  input  logic                  mthi,
  input  logic                  mtlo,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   q_reg, m_reg;
  logic [DATA_WIDTH-1:0]   hi_reg, lo_reg;
  logic [DATA_WIDTH-1:0]   mul_hi, mul_lo;
  logic [2*DATA_WIDTH-1:0] prod_reg;
  logic                    done_reg;
  logic                    accept;

  mul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .Q  (q_reg),
    .M  (m_reg),
    .HI (mul_hi),
    .LO (mul_lo)
  );

  assign ready  = (state_reg == IDLE);
  assign busy   = ~ready;
  assign accept = ready & start;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = EXEC;
      EXEC:    state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= (state_reg == WRITE);
    end
  end

  // Operands are frozen at acceptance so later Q/M changes cannot leak in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg <= '0;
      m_reg <= '0;
    end else if (accept) begin
      q_reg <= Q;
      m_reg <= M;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_reg <= '0;
    end else if (state_reg == EXEC) begin
      prod_reg <= {mul_hi, mul_lo};
    end
  end

  // Product write-back and mthi/mtlo are mutually exclusive: writes only land in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (state_reg == WRITE) begin
      hi_reg <= prod_reg[2*DATA_WIDTH-1:DATA_WIDTH];
      lo_reg <= prod_reg[DATA_WIDTH-1:0];
    end else if (ready) begin
      if (mthi) hi_reg <= wdata;
      if (mtlo) lo_reg <= wdata;
    end
  end

  assign done = done_reg;
  assign HI   = hi_reg;
  assign LO   = lo_reg;

endmodule

// File: doc/hilo_mul_stage.md
HILO_MUL_STAGE -- requirements
Module: hilo_mul_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand and HI/LO register width.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: multiply request, sampled only while ready is high.
REQ-005 SHALL have port Q, input, DATA_WIDTH bits: multiplicand, signed two's complement.
REQ-006 SHALL have port M, input, DATA_WIDTH bits: multiplier, signed two's complement.
REQ-007 SHALL have port mthi, input, 1 bit: write wdata into HI.
REQ-008 SHALL have port mtlo, input, 1 bit: write wdata into LO.
REQ-009 SHALL have port wdata, input, DATA_WIDTH bits: data for mthi/mtlo.
REQ-010 SHALL have port ready, output, 1 bit: high when in IDLE and able to accept start, mthi or mtlo.
REQ-011 SHALL have port busy, output, 1 bit: logical inverse of ready.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse after HI/LO take a new product.
REQ-013 SHALL have port HI, output, DATA_WIDTH bits: architected HI register, driven directly from a flop.
REQ-014 SHALL have port LO, output, DATA_WIDTH bits: architected LO register, driven directly from a flop.

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, EXEC and WRITE.
REQ-016 IDLE with start=1 SHALL latch Q and M into operand registers at the edge and go to EXEC; IDLE with start=0 SHALL stay in IDLE.
REQ-017 EXEC SHALL feed the operand registers to the combinational multiplier, capture the 2*DATA_WIDTH signed product into a product register at the edge, and go to WRITE.
REQ-018 WRITE SHALL load HI with product[2*DATA_WIDTH-1:DATA_WIDTH] and LO with product[DATA_WIDTH-1:0] at the edge, set done=1 for the following cycle only, and go to IDLE.
REQ-019 Latency SHALL be exact: start accepted at edge t0, HI/LO updated at edge t0+2, done high during the cycle between edges t0+2 and t0+3.
REQ-020 The product SHALL be the full signed product, with no truncation or saturation; the most negative operand times itself SHALL give the exact value.
REQ-021 start, mthi and mtlo while ready=0 SHALL be ignored, with no queuing and no effect on HI, LO or the operand registers.
REQ-022 Q and M changes after the accepting edge SHALL NOT affect the in-flight result.
REQ-023 In IDLE, mthi=1 SHALL write HI and mtlo=1 SHALL write LO at the edge; both asserted together SHALL write both registers.
REQ-024 start together with mthi/mtlo in IDLE SHALL perform the write at that edge and accept the multiply; the product SHALL later overwrite HI and LO.
REQ-025 A start in the cycle done is high SHALL be accepted, since the FSM is in IDLE, giving back-to-back throughput of one multiply per 3 cycles.
REQ-026 HI and LO SHALL hold their values in all cycles other than the writes defined in REQ-018 and REQ-023.

Reset
REQ-027 Asserting reset SHALL immediately force state to IDLE, and HI, LO, operand registers, product register and done to 0; ready SHALL be 1.
REQ-028 Reset during EXEC or WRITE SHALL abort the operation, leave no HI/LO update and produce no done pulse after release.
REQ-029 The first start SHALL be accepted at the first rising edge after reset deasserts.

Structure
REQ-030 The FSM state encoding (IDLE=2'd0, EXEC=2'd1, WRITE=2'd2) and the DATA_WIDTH default SHALL be placed in the shared ALU package.
REQ-031 Exactly one sub-module SHALL be used: the existing combinational Booth multiplier mul, instantiated with Q and M driven from the operand registers and HI/LO outputs concatenated into the product register input.
REQ-032 No other arithmetic SHALL be implemented in this block.

Verification
REQ-033 Q=7, M=0xFFFFFFFD with start pulse -> at t0+2, HI=0xFFFFFFFF and LO=0xFFFFFFEB; done high exactly one cycle.
REQ-034 Q=0x80000000, M=0x80000000 -> HI=0x40000000, LO=0x00000000; Q=0x7FFFFFFF, M=0x7FFFFFFF -> HI=0x3FFFFFFF, LO=0x00000001.
REQ-035 start held high continuously with two operand pairs (3 x 4, then -1 x 5) -> products 12 and -5 appear 3 cycles apart; operand changes in EXEC/WRITE are ignored.
REQ-036 mthi with wdata=0xDEADBEEF in IDLE -> HI=0xDEADBEEF next cycle; mtlo asserted during EXEC -> LO unchanged.
REQ-037 reset asserted in EXEC of 2 x 3 -> outputs zero immediately; after release, no done pulse and HI=LO=0.
REQ-038 start+mthi(wdata=0x11) together in IDLE, 5 x 6 -> HI=0x11 for 2 cycles, then HI=0, LO=30.
